sync_fifo: RTL and testbench

Single-clock, first-in-first-out buffer of DATA_SIZE-bit words, depth 2^ADDR_SIZE. Used as a rate/burst decoupler between a producer and a consumer in the same clock domain. Provides full/empty status and rejects overflowing writes and underflowing reads.

---
 rtl/sync_fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 38 +++
 rtl/sync_fifo.sv | 62 ++++++
 tb/tb_sync_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared constants.
// Default geometry for the FIFO and its storage array.
package sync_fifo_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_ADDR_SIZE = 6;
    localparam int DEF_DEPTH     = 2 ** DEF_ADDR_SIZE;
    localparam int DEF_PTR_W     = DEF_ADDR_SIZE + 1;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port array.
// Synchronous write port, registered read port with enable.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // array itself is never reset; only the output register is
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
// Wrap-bit pointers; flags decode the registered pointers.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = ADDR_SIZE + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             w_ok;
    logic             r_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE])
                && (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);

    // each request gated by pre-edge flags; no empty bypass
    assign w_ok = w_en && !full;
    assign r_ok = r_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (w_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (r_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    fifo_mem #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (w_ok),
        .waddr(wptr[ADDR_SIZE-1:0]),
        .wdata(w_data),
        .re   (r_ok && !rst),
        .raddr(rptr[ADDR_SIZE-1:0]),
        .rdata(r_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vectors plus corner-case sequences.
// Default geometry: 8-bit words, 64 entries.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;
    logic [7:0] r_data;
    logic       full;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic       w_en;
        logic [7:0] w_data;
        logic       r_en;
        logic       e_empty;
        logic       e_full;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t vecs [15];

    sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .w_en  (w_en),
        .w_data(w_data),
        .r_en  (r_en),
        .r_data(r_data),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic w, logic [7:0] d,
                                logic rd, logic e, logic f,
                                logic [7:0] q);
        vec_t v;
        v.rst = r; v.w_en = w; v.w_data = d; v.r_en = rd;
        v.e_empty = e; v.e_full = f; v.e_rdata = q;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive inputs, take one rising edge, sample 1 time unit later
    task automatic step(input logic r, input logic w,
                        input logic [7:0] d, input logic rd);
        rst = r; w_en = w; w_data = d; r_en = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; w_data = '0; r_en = 1'b0;
        vecs[0]  = mk(1, 1, 8'h11, 1, 1, 0, 8'h00);
        vecs[1]  = mk(1, 1, 8'h22, 1, 1, 0, 8'h00);
        vecs[2]  = mk(0, 1, 8'hA1, 0, 0, 0, 8'h00);
        vecs[3]  = mk(0, 1, 8'hB2, 0, 0, 0, 8'h00);
        vecs[4]  = mk(0, 1, 8'hC3, 0, 0, 0, 8'h00);
        vecs[5]  = mk(0, 1, 8'hD4, 0, 0, 0, 8'h00);
        vecs[6]  = mk(0, 0, 8'h00, 1, 0, 0, 8'hA1);
        vecs[7]  = mk(0, 0, 8'h00, 1, 0, 0, 8'hB2);
        vecs[8]  = mk(0, 0, 8'h00, 1, 0, 0, 8'hC3);
        vecs[9]  = mk(0, 0, 8'h00, 1, 1, 0, 8'hD4);
        vecs[10] = mk(0, 0, 8'h00, 1, 1, 0, 8'hD4);
        vecs[11] = mk(0, 0, 8'h00, 1, 1, 0, 8'hD4);
        vecs[12] = mk(0, 0, 8'h00, 1, 1, 0, 8'hD4);
        vecs[13] = mk(0, 1, 8'h77, 1, 0, 0, 8'hD4);
        vecs[14] = mk(0, 0, 8'h00, 1, 1, 0, 8'h77);

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].w_en, vecs[i].w_data, vecs[i].r_en);
            chk($sformatf("vec%0d empty", i), 8'(empty), 8'(vecs[i].e_empty));
            chk($sformatf("vec%0d full", i), 8'(full), 8'(vecs[i].e_full));
            chk($sformatf("vec%0d r_data", i), r_data, vecs[i].e_rdata);
        end

        // fill to 64, overflow write dropped, drain in order
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 8'(i), 0);
            chk($sformatf("fill%0d full", i), 8'(full), 8'(i == 63));
        end
        chk("fill empty", 8'(empty), 8'h0);
        step(0, 1, 8'hFF, 0);
        chk("ovf full", 8'(full), 8'h1);
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 8'h00, 1);
            chk($sformatf("drain%0d", i), r_data, 8'(i));
            chk($sformatf("drain%0d full", i), 8'(full), 8'h0);
        end
        chk("drain empty", 8'(empty), 8'h1);

        // steady state w+r with 10 stored, crossing pointer wrap
        for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h80 + i), 0);
        for (int k = 0; k < 100; k++) begin
            step(0, 1, 8'(8'h80 + 10 + k), 1);
            chk($sformatf("ss%0d", k), r_data, 8'(8'h80 + k));
            chk($sformatf("ss%0d empty", k), 8'(empty), 8'h0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 1);
            chk($sformatf("ssdrain%0d", i), r_data, 8'(8'h80 + 100 + i));
        end
        chk("ssdrain empty", 8'(empty), 8'h1);

        // full with w+r: only the read happens
        for (int i = 0; i < 64; i++) step(0, 1, 8'(8'h40 + i), 0);
        chk("refill full", 8'(full), 8'h1);
        step(0, 1, 8'hEE, 1);
        chk("fullrw r_data", r_data, 8'h40);
        chk("fullrw full", 8'(full), 8'h0);
        step(0, 1, 8'h99, 0);
        chk("fullrw refull", 8'(full), 8'h1);
        for (int i = 1; i < 64; i++) begin
            step(0, 0, 8'h00, 1);
            chk($sformatf("fulldrain%0d", i), r_data, 8'(8'h40 + i));
        end
        step(0, 0, 8'h00, 1);
        chk("fulldrain last", r_data, 8'h99);
        chk("fulldrain empty", 8'(empty), 8'h1);

        // reset mid-operation with 20 stored
        for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h10 + i), 0);
        step(1, 0, 8'h00, 0);
        chk("mrst empty", 8'(empty), 8'h1);
        chk("mrst full", 8'(full), 8'h0);
        chk("mrst r_data", r_data, 8'h00);
        step(0, 1, 8'h5A, 0);
        chk("post-rst empty", 8'(empty), 8'h0);
        step(0, 0, 8'h00, 1);
        chk("post-rst r_data", r_data, 8'h5A);
        chk("post-rst drained", 8'(empty), 8'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
